// File: rtl/uart_tx_if.sv
// Producer-facing bundle of the UART transmitter: byte handshake plus line/status outputs.
interface uart_tx_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 ready;
  logic                 txd;
  logic                 busy;
  logic                 done;

  modport master (output data, valid, input ready, txd, busy, done);
  modport slave  (input data, valid, output ready, txd, busy, done);
endinterface

// File: rtl/uart_tx.sv
// Asynchronous serial transmitter with internal bit-period divider, optional parity and 1/2 stop bits.
// All outputs are registered; a new byte may be accepted in the last clock of a frame for gapless streaming.
module uart_tx #(
  parameter int DIVISOR   = 16,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic     clock,
  input  logic     reset,
  uart_tx_if.slave bus
);
  localparam int DIV_W = $clog2(DIVISOR);
  localparam int BIT_W = $clog2(DATA_BITS);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIVISOR - 1);
  localparam logic [DIV_W-1:0] DIV_PRE   = DIV_W'(DIVISOR - 2);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               r_state;
  logic [DIV_W-1:0]     r_div;
  logic [BIT_W-1:0]     r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par;
  logic                 r_txd;
  logic                 r_ready;
  logic                 r_busy;
  logic                 r_done;

  logic w_accept;
  logic w_par;

  assign w_accept = bus.valid & r_ready;
  // Odd parity is the complement of the even (plain XOR) parity bit.
  assign w_par    = (^bus.data) ^ (PARITY == 1);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_div   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_txd   <= 1'b1;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_state <= S_START;
        r_div   <= '0;
        r_bit   <= '0;
        r_shift <= bus.data;
        r_par   <= w_par;
        r_txd   <= 1'b0;
        r_ready <= 1'b0;
        r_busy  <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_txd <= 1'b1;
          end
          S_START: begin
            if (r_div == DIV_LAST) begin
              r_div   <= '0;
              r_state <= S_DATA;
              r_txd   <= r_shift[0];
              r_shift <= r_shift >> 1;
            end else begin
              r_div <= r_div + DIV_W'(1);
            end
          end
          S_DATA: begin
            if (r_div == DIV_LAST) begin
              r_div <= '0;
              if (r_bit == BIT_LAST) begin
                r_bit <= '0;
                if (PARITY != 0) begin
                  r_state <= S_PARITY;
                  r_txd   <= r_par;
                end else begin
                  r_state <= S_STOP;
                  r_txd   <= 1'b1;
                end
              end else begin
                r_bit   <= r_bit + BIT_W'(1);
                r_txd   <= r_shift[0];
                r_shift <= r_shift >> 1;
              end
            end else begin
              r_div <= r_div + DIV_W'(1);
            end
          end
          S_PARITY: begin
            if (r_div == DIV_LAST) begin
              r_div   <= '0;
              r_state <= S_STOP;
              r_txd   <= 1'b1;
            end else begin
              r_div <= r_div + DIV_W'(1);
            end
          end
          S_STOP: begin
            // Announce the final clock one edge early so done/ready are registered into it.
            if (r_div == DIV_PRE && r_bit == STOP_LAST) begin
              r_done  <= 1'b1;
              r_ready <= 1'b1;
            end
            if (r_div == DIV_LAST) begin
              r_div <= '0;
              if (r_bit == STOP_LAST) begin
                r_bit   <= '0;
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
                r_ready <= 1'b1;
              end else begin
                r_bit <= r_bit + BIT_W'(1);
              end
            end else begin
              r_div <= r_div + DIV_W'(1);
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_txd   <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.txd   = r_txd;
  assign bus.ready = r_ready;
  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench: decoding monitor + frame scoreboard on an 8N1 instance, per-clock checks on parity and 5N2 instances.
module tb_uart_tx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;

  uart_tx_if #(.DATA_BITS(8)) m_if ();
  uart_tx_if #(.DATA_BITS(8)) pe_if ();
  uart_tx_if #(.DATA_BITS(8)) po_if ();
  uart_tx_if #(.DATA_BITS(5)) s_if ();

  uart_tx #(.DIVISOR(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_main (
    .clock(clk), .reset(rst), .bus(m_if));
  uart_tx #(.DIVISOR(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_even (
    .clock(clk), .reset(rst), .bus(pe_if));
  uart_tx #(.DIVISOR(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_odd (
    .clock(clk), .reset(rst), .bus(po_if));
  uart_tx #(.DIVISOR(2), .DATA_BITS(5), .PARITY(0), .STOP_BITS(2)) u_5n2 (
    .clock(clk), .reset(rst), .bus(s_if));

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;  // line bits in time order, bit 0 = start
  } vec_t;
  vec_t vecs[6];

  logic [9:0] sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Decoder for the 8N1 instance: samples each bit mid-period and scores the frame.
  int         fcnt = 0;
  logic       in_frame = 1'b0;
  logic [9:0] cap;
  logic [9:0] exp_f;
  always @(negedge clk) begin
    if (m_if.done) done_cnt++;
    if (!in_frame && m_if.busy && m_if.txd == 1'b0) begin
      in_frame = 1'b1;
      fcnt = 0;
      cap = '0;
    end
    if (in_frame) begin
      if (!m_if.busy) begin
        in_frame = 1'b0;
      end else begin
        if (fcnt % 4 == 2) cap[fcnt/4] = m_if.txd;
        if (fcnt == 39) begin
          in_frame = 1'b0;
          check("mon_done_last_clk", m_if.done, 1);
          if (sb.size() == 0) begin
            check("mon_unexpected_frame", cap, 10'h3ff);
          end else begin
            exp_f = sb.pop_front();
            check("mon_frame", cap, exp_f);
            $display("frame data=%02h expected=%02h cycle=%0d", cap[8:1], exp_f[8:1], cyc);
          end
        end
        fcnt++;
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic [9:0] f);
    int n = 0;
    @(negedge clk);
    while (!m_if.ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!m_if.ready) begin
      check("send_ready_timeout", 0, 1);
      return;
    end
    m_if.data  = d;
    m_if.valid = 1'b1;
    sb.push_back(f);
    @(posedge clk);
    #1;
    m_if.valid = 1'b0;
    m_if.data  = ~d;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (m_if.busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", m_if.busy, 0);
  endtask

  int         dc0;
  int         rc;
  logic [9:0] f55;
  logic [10:0] fe;
  logic [10:0] fo;
  logic [7:0] fs;

  initial begin
    m_if.valid = 1'b0;  m_if.data = '0;
    pe_if.valid = 1'b0; pe_if.data = '0;
    po_if.valid = 1'b0; po_if.data = '0;
    s_if.valid = 1'b0;  s_if.data = '0;

    vecs[0] = '{8'h55, 10'b1010101010};
    vecs[1] = '{8'h00, 10'b1000000000};
    vecs[2] = '{8'hFF, 10'b1111111110};
    vecs[3] = '{8'h01, 10'b1000000010};
    vecs[4] = '{8'h80, 10'b1100000000};
    vecs[5] = '{8'hC3, 10'b1110000110};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_txd", m_if.txd, 1);
    check("rst_ready", m_if.ready, 1);
    check("rst_busy", m_if.busy, 0);
    check("rst_done", m_if.done, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 0x55 clock-exact frame timing
    f55 = 10'b1010101010;
    send(8'h55, f55);
    for (int k = 1; k <= 41; k++) begin
      @(negedge clk);
      if (k <= 40) check($sformatf("t55_txd_k%0d", k), m_if.txd, f55[(k-1)/4]);
      check($sformatf("t55_done_k%0d", k), m_if.done, (k == 40) ? 1 : 0);
      if (k == 1)  begin check("t55_ready_k1", m_if.ready, 0); check("t55_busy_k1", m_if.busy, 1); end
      if (k == 40) begin check("t55_ready_k40", m_if.ready, 1); check("t55_busy_k40", m_if.busy, 1); end
      if (k == 41) begin
        check("t55_ready_k41", m_if.ready, 1);
        check("t55_busy_k41", m_if.busy, 0);
        check("t55_txd_k41", m_if.txd, 1);
      end
    end

    // Table of bytes through the scoreboard
    for (int i = 0; i < 6; i++) begin
      send(vecs[i].data, vecs[i].frame);
      wait_idle();
    end
    check("table_sb_empty", sb.size(), 0);

    // Back-to-back with valid held high
    @(negedge clk);
    m_if.data  = 8'hA5;
    m_if.valid = 1'b1;
    sb.push_back(10'b1101001010);
    sb.push_back(10'b1001111000);
    @(posedge clk);
    #1;
    m_if.data = 8'h3C;
    rc = 0;
    for (int k = 1; k <= 41; k++) begin
      @(negedge clk);
      if (m_if.ready) rc++;
      if (k == 1) check("b2b_first_start", m_if.txd, 0);
      if (k == 41) begin
        check("b2b_second_start", m_if.txd, 0);
        check("b2b_second_busy", m_if.busy, 1);
        check("b2b_ready_clocks", rc, 1);
        m_if.valid = 1'b0;
      end
    end
    wait_idle();
    check("b2b_sb_empty", sb.size(), 0);

    // valid pulsed mid-frame is ignored
    dc0 = done_cnt;
    send(8'h00, 10'b1000000000);
    repeat (12) @(negedge clk);
    check("mid_ready_low", m_if.ready, 0);
    m_if.data  = 8'hFF;
    m_if.valid = 1'b1;
    @(posedge clk);
    #1;
    m_if.valid = 1'b0;
    wait_idle();
    repeat (60) @(negedge clk);
    check("mid_done_count", done_cnt - dc0, 1);
    check("mid_sb_empty", sb.size(), 0);

    // Reset at frame clock 13
    dc0 = done_cnt;
    send(8'h5A, 10'b1010110100);
    for (int k = 1; k <= 13; k++) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_txd", m_if.txd, 1);
    check("abort_ready", m_if.ready, 1);
    check("abort_busy", m_if.busy, 0);
    sb.delete();
    repeat (50) @(negedge clk);
    check("abort_no_done", done_cnt - dc0, 0);
    send(8'hC3, 10'b1110000110);
    wait_idle();
    check("abort_after_sb_empty", sb.size(), 0);

    // Reset coincident with a valid handshake
    dc0 = done_cnt;
    @(negedge clk);
    rst = 1'b1;
    m_if.data  = 8'h0F;
    m_if.valid = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_if.valid = 1'b0;
    @(negedge clk);
    check("rstwin_busy", m_if.busy, 0);
    check("rstwin_txd", m_if.txd, 1);
    repeat (50) @(negedge clk);
    check("rstwin_no_done", done_cnt - dc0, 0);

    // Even / odd parity on 0x07
    fe = 11'b11000001110;
    fo = 11'b10000001110;
    @(negedge clk);
    pe_if.data = 8'h07; pe_if.valid = 1'b1;
    po_if.data = 8'h07; po_if.valid = 1'b1;
    @(posedge clk);
    #1;
    pe_if.valid = 1'b0; po_if.valid = 1'b0;
    pe_if.data = 8'hF8; po_if.data = 8'hF8;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      if (k <= 44) begin
        check($sformatf("even_txd_k%0d", k), pe_if.txd, fe[(k-1)/4]);
        check($sformatf("odd_txd_k%0d", k), po_if.txd, fo[(k-1)/4]);
      end
      check($sformatf("even_done_k%0d", k), pe_if.done, (k == 44) ? 1 : 0);
      check($sformatf("odd_done_k%0d", k), po_if.done, (k == 44) ? 1 : 0);
      if (k == 45) begin
        check("even_busy_end", pe_if.busy, 0);
        check("odd_busy_end", po_if.busy, 0);
      end
    end

    // 5 data bits, 2 stop bits, divisor 2, data 0x13
    fs = 8'b11100110;
    @(negedge clk);
    s_if.data = 5'h13; s_if.valid = 1'b1;
    @(posedge clk);
    #1;
    s_if.valid = 1'b0;
    s_if.data  = 5'h0C;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      if (k <= 16) check($sformatf("s52_txd_k%0d", k), s_if.txd, fs[(k-1)/2]);
      check($sformatf("s52_done_k%0d", k), s_if.done, (k == 16) ? 1 : 0);
      if (k == 16) check("s52_ready_last", s_if.ready, 1);
      if (k == 17) check("s52_busy_end", s_if.busy, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
